min_search_sched: RTL and testbench

- Round-robin scheduler that shares one two-minimum finder (ED/node sorter) among NREQ detection-layer requesters.
- For each granted job it:
  - walks the requester's candidate buffer by index;
  - streams ED/node pairs into the min finder with its enable held high for exactly the job length;
  - drops enable so the finder clears;
  - captures min1/min2 and returns them tagged with the requester ID.
- Sits between the per-layer candidate buffers and the shared min finder.

---
 rtl/min_search_sched.sv | 167 ++++++++++++++++
 tb/tb_min_search_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_search_sched.sv
// Round-robin scheduler sharing one two-minimum finder among NREQ candidate buffers.
// Each granted job streams len ED/node pairs into the finder and returns its two minima.
module min_search_sched #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 7,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic                    rd_en,
  output logic [CNT_W-1:0]        rd_idx,
  input  logic [31:0]             rd_ed,
  input  logic [31:0]             rd_node,
  output logic                    mf_enable,
  output logic [31:0]             mf_ed,
  output logic [31:0]             mf_node,
  input  logic [31:0]             mf_min1_node,
  input  logic [31:0]             mf_min2_node,
  input  logic [31:0]             mf_min1_ed,
  input  logic [31:0]             mf_min2_ed,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [31:0]             res_min1_node,
  output logic [31:0]             res_min2_node,
  output logic [31:0]             res_min1_ed,
  output logic [31:0]             res_min2_ed,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  idx;
  logic              drain_cnt;
  logic              rd_en_d1;

  logic              any_req;
  logic              found;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   ptr_nxt;
  logic [CNT_W-1:0]  pick_slice;
  logic [CNT_W-1:0]  pick_len;
  logic              last_rd;

  // Arbitration: first set request at or after the pointer, wrapping around.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == ID_W'(i)) pick_slice = req_len[i*CNT_W +: CNT_W];
    end
  end

  assign any_req  = |req;
  assign pick_len = (pick_slice > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : pick_slice;
  assign ptr_nxt  = (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
  assign last_rd  = (idx == len - 1'b1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = (pick_len == '0) ? DONE : READ;
      READ:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      winner        <= '0;
      len           <= '0;
      idx           <= '0;
      drain_cnt     <= 1'b0;
      gnt           <= '0;
      res_min1_node <= '0;
      res_min2_node <= '0;
      res_min1_ed   <= '0;
      res_min2_ed   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= NREQ'(1) << pick;
            winner    <= pick;
            len       <= pick_len;
            ptr       <= ptr_nxt;
            idx       <= '0;
            drain_cnt <= 1'b0;
            // An empty job never reaches the finder, so report "no candidate".
            if (pick_len == '0) begin
              res_min1_node <= '1;
              res_min2_node <= '1;
              res_min1_ed   <= '1;
              res_min2_ed   <= '1;
            end
          end
        end
        READ:    idx <= last_rd ? '0 : idx + 1'b1;
        DRAIN:   drain_cnt <= ~drain_cnt;
        CAPTURE: begin
          res_min1_node <= mf_min1_node;
          res_min2_node <= mf_min2_node;
          res_min1_ed   <= mf_min1_ed;
          res_min2_ed   <= mf_min2_ed;
        end
        DONE:    gnt <= '0;
        default: ;
      endcase
    end
  end

  // Buffer data arrives one cycle after rd_en and is registered once more,
  // so mf_enable trails rd_en by two cycles to stay aligned with mf_ed/mf_node.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_d1  <= 1'b0;
      mf_enable <= 1'b0;
      mf_ed     <= '0;
      mf_node   <= '0;
    end else begin
      rd_en_d1  <= rd_en;
      mf_enable <= rd_en_d1;
      if (rd_en_d1) begin
        mf_ed   <= rd_ed;
        mf_node <= rd_node;
      end
    end
  end

  assign rd_en     = (state == READ);
  assign rd_idx    = idx;
  assign res_valid = (state == DONE);
  assign res_id    = res_valid ? winner : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_min_search_sched.sv
// Self-checking bench: candidate buffers and a two-minimum finder are modelled here,
// and every job result is compared with a reference selection over the buffer contents.
module tb_min_search_sched;
  localparam int NREQ = 4, MAX_LEN = 64, CNT_W = 7, ID_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic                  rd_en;
  logic [CNT_W-1:0]      rd_idx;
  logic [31:0]           rd_ed, rd_node;
  logic                  mf_enable;
  logic [31:0]           mf_ed, mf_node;
  logic [31:0]           mf_min1_node, mf_min2_node, mf_min1_ed, mf_min2_ed;
  logic                  res_valid;
  logic [ID_W-1:0]       res_id;
  logic [31:0]           res_min1_node, res_min2_node, res_min1_ed, res_min2_ed;
  logic                  busy;

  min_search_sched #(.NREQ(NREQ), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_ed(rd_ed), .rd_node(rd_node),
    .mf_enable(mf_enable), .mf_ed(mf_ed), .mf_node(mf_node),
    .mf_min1_node(mf_min1_node), .mf_min2_node(mf_min2_node),
    .mf_min1_ed(mf_min1_ed), .mf_min2_ed(mf_min2_ed),
    .res_valid(res_valid), .res_id(res_id),
    .res_min1_node(res_min1_node), .res_min2_node(res_min2_node),
    .res_min1_ed(res_min1_ed), .res_min2_ed(res_min2_ed), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned ed_mem   [NREQ][MAX_LEN];
  int unsigned node_mem [NREQ][MAX_LEN];
  int          lens     [NREQ];

  // Candidate buffers: one-cycle read latency, bank chosen by the grant.
  always @(posedge clk) begin : buf_model
    int s;
    s = 0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) s = i;
    if (rd_en) begin
      rd_ed   <= (int'(rd_idx) < MAX_LEN) ? ed_mem[s][rd_idx]   : 32'hFFFF_FFFF;
      rd_node <= (int'(rd_idx) < MAX_LEN) ? node_mem[s][rd_idx] : 32'hFFFF_FFFF;
    end
  end

  // Shared finder: clears while disabled, keeps two smallest EDs (first arrival wins ties).
  always @(posedge clk) begin
    if (!mf_enable) begin
      mf_min1_ed <= '1; mf_min1_node <= '1; mf_min2_ed <= '1; mf_min2_node <= '1;
    end else if (mf_ed < mf_min1_ed) begin
      mf_min2_ed <= mf_min1_ed; mf_min2_node <= mf_min1_node;
      mf_min1_ed <= mf_ed;      mf_min1_node <= mf_node;
    end else if (mf_ed < mf_min2_ed) begin
      mf_min2_ed <= mf_ed;      mf_min2_node <= mf_node;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Per-job observations, taken on the falling edge.
  int rd_cnt = 0, mf_cnt = 0, idx_err = 0, gnt_multi = 0, gnt_start = 0;
  int low_run = 0, min_gap = 1000, job_rd = 0, job_mf = 0, job_lat = 0, vcount = 0;
  bit prev_gnt_any = 1'b0, seen_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; mf_cnt = 0; prev_gnt_any = 1'b0; low_run = 0; seen_en = 1'b0;
    end else begin
      if ($countones(gnt) > 1) gnt_multi++;
      if (gnt != '0 && !prev_gnt_any) gnt_start = cyc;
      prev_gnt_any = (gnt != '0);
      if (rd_en) begin
        if (rd_idx != CNT_W'(rd_cnt)) idx_err++;
        rd_cnt++;
      end
      if (!mf_enable) low_run++;
      else begin
        if (seen_en && low_run > 0 && low_run < min_gap) min_gap = low_run;
        low_run = 0; seen_en = 1'b1; mf_cnt++;
      end
      if (res_valid) begin
        job_rd = rd_cnt; job_mf = mf_cnt; job_lat = cyc - gnt_start;
        rd_cnt = 0; mf_cnt = 0; vcount++;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_job(input int id, input int n);
    lens[id] = n;
    req_len[id*CNT_W +: CNT_W] = CNT_W'(n);
  endtask

  task automatic fill_random(input int id, input int maxv);
    for (int i = 0; i < MAX_LEN; i++) begin
      ed_mem[id][i]   = $urandom_range(0, maxv);
      node_mem[id][i] = $urandom_range(0, 100000);
    end
  endtask

  // Reference: smallest ED (earliest index on ties), then smallest of the rest.
  task automatic ref_mins(input int id, input int n,
                          output logic [31:0] e1, n1, e2, n2);
    int b1, b2;
    b1 = -1; b2 = -1;
    for (int i = 0; i < n; i++)
      if (b1 < 0 || ed_mem[id][i] < ed_mem[id][b1]) b1 = i;
    for (int i = 0; i < n; i++)
      if (i != b1 && (b2 < 0 || ed_mem[id][i] < ed_mem[id][b2])) b2 = i;
    e1 = (b1 < 0) ? 32'hFFFF_FFFF : ed_mem[id][b1];
    n1 = (b1 < 0) ? 32'hFFFF_FFFF : node_mem[id][b1];
    e2 = (b2 < 0) ? 32'hFFFF_FFFF : ed_mem[id][b2];
    n2 = (b2 < 0) ? 32'hFFFF_FFFF : node_mem[id][b2];
  endtask

  int model_ptr = 0;
  int served[$];

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic serve(input logic [NREQ-1:0] mask, input int njobs, input bit hold);
    req = mask;
    for (int j = 0; j < njobs; j++) begin
      int exp_id, n, waited;
      logic [31:0] e1, n1, e2, n2;
      exp_id = -1;
      for (int k = 0; k < NREQ; k++)
        if (exp_id < 0 && req[(model_ptr + k) % NREQ]) exp_id = (model_ptr + k) % NREQ;
      if (exp_id < 0) break;
      waited = 0;
      do begin
        @(negedge clk); #1; waited++;
      end while (!res_valid && waited < 400);
      check("res_timeout", 32'(res_valid), 32'd1);
      if (!res_valid) begin
        req = '0;
        return;
      end
      n = (lens[exp_id] > MAX_LEN) ? MAX_LEN : lens[exp_id];
      ref_mins(exp_id, n, e1, n1, e2, n2);
      check("res_id",   32'(res_id), 32'(exp_id));
      check("gnt_held", 32'(gnt), 32'(1 << exp_id));
      check("min1_ed",  res_min1_ed, e1);
      check("min1_node", res_min1_node, n1);
      check("min2_ed",  res_min2_ed, e2);
      check("min2_node", res_min2_node, n2);
      check("rd_count", 32'(job_rd), 32'(n));
      check("en_count", 32'(job_mf), 32'(n));
      if (n > 0) check("latency", 32'(job_lat), 32'(n + 3));
      served.push_back(exp_id);
      model_ptr = (exp_id + 1) % NREQ;
      if (!hold) req[exp_id] = 1'b0;
    end
    req = '0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int found, vc;
    rst = 1'b1; req = '0; req_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      fill_random(i, 1000);
      lens[i] = 0;
    end
    do_reset();
    check("reset_ctrl", 32'({gnt, rd_en, rd_idx, mf_enable, res_valid, res_id, busy}), 32'd0);
    check("reset_data", mf_ed | mf_node | res_min1_ed | res_min2_ed | res_min1_node | res_min2_node, 32'd0);

    // Single job with a tied minimum.
    ed_mem[0][0] = 7; ed_mem[0][1] = 3; ed_mem[0][2] = 9; ed_mem[0][3] = 3;
    for (int i = 0; i < 4; i++) node_mem[0][i] = 10 + i;
    set_job(0, 4);
    serve(4'b0001, 1, 1'b0);
    check("t1_min1_ed", res_min1_ed, 32'd3);
    check("t1_min1_node", res_min1_node, 32'd11);
    check("t1_min2_ed", res_min2_ed, 32'd3);
    check("t1_min2_node", res_min2_node, 32'd13);

    // Single candidate: second slot stays empty.
    ed_mem[0][0] = 5; node_mem[0][0] = 2;
    set_job(0, 1);
    serve(4'b0001, 1, 1'b0);
    check("t2_min1", {res_min1_ed[15:0], res_min1_node[15:0]}, {16'd5, 16'd2});
    check("t2_min2_ed", res_min2_ed, 32'hFFFF_FFFF);

    // Round-robin with both requests held.
    do_reset();
    served.delete();
    fill_random(1, 1000); fill_random(3, 1000);
    set_job(1, 2); set_job(3, 2);
    serve(4'b1010, 4, 1'b1);
    check("rr_jobs", 32'(served.size()), 32'd4);
    if (served.size() == 4) begin
      check("rr_order", {8'(served[0]), 8'(served[1]), 8'(served[2]), 8'(served[3])},
            {8'd1, 8'd3, 8'd1, 8'd3});
    end

    // Zero-length job.
    set_job(2, 0);
    serve(4'b0100, 1, 1'b0);
    check("zero_id", 32'(served[$]), 32'd2);
    check("zero_min1", res_min1_ed & res_min1_node, 32'hFFFF_FFFF);

    // Back-to-back jobs: no carry-over, enable gap.
    ed_mem[0][0] = 1; ed_mem[0][1] = 2; node_mem[0][0] = 100; node_mem[0][1] = 101;
    ed_mem[1][0] = 8; ed_mem[1][1] = 9; node_mem[1][0] = 200; node_mem[1][1] = 201;
    set_job(0, 2); set_job(1, 2);
    min_gap = 1000;
    serve(4'b0011, 2, 1'b0);
    check("b2b_min1_ed", res_min1_ed, 32'd8);
    check("b2b_min2_ed", res_min2_ed, 32'd9);
    check("en_gap_ge4", 32'(min_gap >= 4), 32'd1);

    // Over-length request is clamped.
    fill_random(3, 1000);
    set_job(3, 70);
    serve(4'b1000, 1, 1'b0);

    // Randomized rounds with heavy ED ties.
    for (int r = 0; r < 8; r++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        fill_random(i, 20);
        set_job(i, ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 12));
      end
      serve(m, $countones(m), 1'b0);
    end

    // Reset in the middle of a long job.
    fill_random(2, 1000);
    set_job(2, 10);
    req = 4'b0100;
    found = 0;
    for (int w = 0; w < 100 && found == 0; w++) begin
      @(negedge clk); #1;
      if (rd_en && rd_idx == CNT_W'(3)) found = 1;
    end
    check("abort_reach_read", 32'(found), 32'd1);
    rst = 1'b1;
    vc = vcount;
    @(negedge clk); #1;
    check("abort_ctrl", 32'({gnt, rd_en, rd_idx, mf_enable, res_valid, res_id, busy}), 32'd0);
    check("abort_data", mf_ed | mf_node | res_min1_ed | res_min2_ed, 32'd0);
    rst = 1'b0; req = '0; model_ptr = 0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_valid", 32'(vcount), 32'(vc));
    fill_random(0, 1000); fill_random(3, 1000);
    set_job(0, 3); set_job(3, 3);
    served.delete();
    serve(4'b1001, 2, 1'b0);
    check("post_reset_first", 32'(served.size() > 0 ? served[0] : -1), 32'd0);

    check("gnt_onehot", 32'(gnt_multi), 32'd0);
    check("rd_idx_seq", 32'(idx_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
